count_seq_checker: RTL and testbench

COUNT_SEQ_CHECKER -- requirements
Module: count_seq_checker

---
 rtl/count_seq_pkg.sv | 15 +
 rtl/count_seq_checker_sat_counter.sv | 28 ++
 rtl/count_seq_checker.sv | 143 ++++++++++++++
 tb/tb_count_seq_checker.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/count_seq_pkg.sv
// Shared types and default parameter values for the counter-sequence checker.
package count_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        LOCKED = 2'd2
    } seq_state_t;

    localparam int DEF_WIDTH    = 8;
    localparam int DEF_LOCK_CNT = 4;
    localparam int DEF_LOSS_CNT = 3;
    localparam int DEF_ERR_W    = 16;

endpackage

// File: rtl/count_seq_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module seq_sat_counter #(
    parameter int ERR_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [ERR_W-1:0] count
);

    localparam logic [ERR_W-1:0] ONE = {{(ERR_W-1){1'b0}}, 1'b1};

    logic [ERR_W-1:0] count_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (inc && (count_reg != '1)) begin
            count_reg <= count_reg + ONE;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/count_seq_checker.sv
// Locks onto a free-running upstream counter and counts sequence errors while locked.
// Define COUNT_SEQ_CHECKER_STATS_EN to enable the accepted-sample counter.
module count_seq_checker
    import count_seq_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int LOCK_CNT = DEF_LOCK_CNT,
    parameter int LOSS_CNT = DEF_LOSS_CNT,
    parameter int ERR_W    = DEF_ERR_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sample_valid,
    input  logic [WIDTH-1:0] sample,
    input  logic             clear,
    output logic             locked,
    output logic [1:0]       state,
    output logic [WIDTH-1:0] expected,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic [ERR_W-1:0] sample_count
);

    localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [3:0]       LOCK_C = 4'(LOCK_CNT);
    localparam logic [3:0]       LOSS_C = 4'(LOSS_CNT);

    seq_state_t       state_reg, state_next;
    logic [3:0]       run_reg, run_next;
    logic [3:0]       miss_reg, miss_next;
    logic [WIDTH-1:0] expected_reg, expected_next;
    logic             locked_reg, locked_next;
    logic             err_pulse_reg, err_pulse_next;
    logic             err_inc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            run_reg       <= '0;
            miss_reg      <= '0;
            expected_reg  <= '0;
            locked_reg    <= 1'b0;
            err_pulse_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            run_reg       <= run_next;
            miss_reg      <= miss_next;
            expected_reg  <= expected_next;
            locked_reg    <= locked_next;
            err_pulse_reg <= err_pulse_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        run_next       = run_reg;
        miss_next      = miss_reg;
        expected_next  = expected_reg;
        err_pulse_next = 1'b0;
        err_inc        = 1'b0;

        if (clear) begin
            // clear has priority; any sample presented alongside it is dropped
            state_next    = IDLE;
            run_next      = '0;
            miss_next     = '0;
            expected_next = '0;
        end else if (sample_valid) begin
            case (state_reg)
                IDLE: begin
                    state_next    = SEARCH;
                    run_next      = 4'd1;
                    expected_next = sample + ONE_W;
                end
                SEARCH: begin
                    if (sample == expected_reg) begin
                        run_next      = run_reg + 4'd1;
                        expected_next = expected_reg + ONE_W;
                        if ((run_reg + 4'd1) >= LOCK_C) begin
                            state_next = LOCKED;
                            miss_next  = '0;
                        end
                    end else begin
                        run_next      = 4'd1;
                        expected_next = sample + ONE_W;
                    end
                end
                LOCKED: begin
                    if (sample == expected_reg) begin
                        expected_next = expected_reg + ONE_W;
                        miss_next     = '0;
                    end else begin
                        err_pulse_next = 1'b1;
                        err_inc        = 1'b1;
                        if ((miss_reg + 4'd1) >= LOSS_C) begin
                            // too many misses: fall back and resync on this sample
                            state_next    = SEARCH;
                            run_next      = 4'd1;
                            miss_next     = '0;
                            expected_next = sample + ONE_W;
                        end else begin
                            miss_next     = miss_reg + 4'd1;
                            expected_next = expected_reg + ONE_W;
                        end
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
        locked_next = (state_next == LOCKED);
    end

    seq_sat_counter #(.ERR_W(ERR_W)) u_err_counter (
        .clk   (clk),
        .reset (reset),
        .clr   (clear),
        .inc   (err_inc),
        .count (err_count)
    );

`ifdef COUNT_SEQ_CHECKER_STATS_EN
    logic sample_inc;
    assign sample_inc = sample_valid && !clear;

    seq_sat_counter #(.ERR_W(ERR_W)) u_sample_counter (
        .clk   (clk),
        .reset (reset),
        .clr   (clear),
        .inc   (sample_inc),
        .count (sample_count)
    );
`else
    assign sample_count = '0;
`endif

    assign state     = state_reg;
    assign locked    = locked_reg;
    assign expected  = expected_reg;
    assign err_pulse = err_pulse_reg;

endmodule

// File: tb/tb_count_seq_checker.sv
// Directed self-checking bench for count_seq_checker (ERR_W reduced to 4 to reach saturation).
module tb_count_seq_checker;

    localparam int WIDTH = 8;
    localparam int ERR_W = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             sample_valid = 1'b0;
    logic [WIDTH-1:0] sample = '0;
    logic             clear = 1'b0;
    logic             locked;
    logic [1:0]       state;
    logic [WIDTH-1:0] expected;
    logic             err_pulse;
    logic [ERR_W-1:0] err_count;
    logic [ERR_W-1:0] sample_count;

    int checks = 0;
    int failures = 0;

    count_seq_checker #(
        .WIDTH    (WIDTH),
        .LOCK_CNT (4),
        .LOSS_CNT (3),
        .ERR_W    (ERR_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .sample       (sample),
        .clear        (clear),
        .locked       (locked),
        .state        (state),
        .expected     (expected),
        .err_pulse    (err_pulse),
        .err_count    (err_count),
        .sample_count (sample_count)
    );

    always #5 clk = ~clk;

    // Present one valid sample, let it be taken, return 1 time unit after the edge.
    task automatic send(input logic [WIDTH-1:0] v);
        sample_valid = 1'b1;
        sample = v;
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        $display("txn: sample=%0d state=%0d locked=%0b expected=%0d err_pulse=%0b err_count=%0d sample_count=%0d",
                 v, state, locked, expected, err_pulse, err_count, sample_count);
    endtask

    task automatic idle_cycle();
        sample_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    task automatic lock_from(input logic [WIDTH-1:0] base);
        for (int i = 0; i < 4; i++) send(base + WIDTH'(i));
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #3;
        checks++; if (state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d want=0", state); end
        checks++; if (locked !== 1'b0 || err_pulse !== 1'b0) begin failures++; $display("FAIL reset_flags got locked=%0b pulse=%0b want 0 0", locked, err_pulse); end
        checks++; if (expected !== 8'd0) begin failures++; $display("FAIL reset_expected got=%0d want=0", expected); end
        checks++; if (err_count !== 4'd0 || sample_count !== 4'd0) begin failures++; $display("FAIL reset_counts got err=%0d smp=%0d want 0 0", err_count, sample_count); end
        #9;
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_lock();
        send(8'd10);
        checks++; if (state !== 2'd1 || expected !== 8'd11) begin failures++; $display("FAIL first_sample got state=%0d exp=%0d want 1 11", state, expected); end
        send(8'd11);
        send(8'd12);
        checks++; if (locked !== 1'b0) begin failures++; $display("FAIL early_lock got=%0b want=0", locked); end
        send(8'd13);
        checks++; if (locked !== 1'b1 || state !== 2'd2) begin failures++; $display("FAIL lock got locked=%0b state=%0d want 1 2", locked, state); end
        checks++; if (expected !== 8'd14 || err_count !== 4'd0) begin failures++; $display("FAIL lock_exp got exp=%0d err=%0d want 14 0", expected, err_count); end
        for (int i = 0; i < 3; i++) idle_cycle();
        checks++; if (expected !== 8'd14 || state !== 2'd2 || err_pulse !== 1'b0) begin failures++; $display("FAIL idle_hold got exp=%0d state=%0d pulse=%0b want 14 2 0", expected, state, err_pulse); end
    endtask

    task automatic test_wrap();
        do_clear();
        lock_from(8'd246);
        checks++; if (locked !== 1'b1 || expected !== 8'd250) begin failures++; $display("FAIL wrap_setup got locked=%0b exp=%0d want 1 250", locked, expected); end
        for (int v = 250; v < 258; v++) begin
            send(8'(v));
            checks++; if (err_pulse !== 1'b0) begin failures++; $display("FAIL wrap_pulse sample=%0d got=%0b want=0", v % 256, err_pulse); end
        end
        checks++; if (locked !== 1'b1 || expected !== 8'd2 || err_count !== 4'd0) begin failures++; $display("FAIL wrap_end got locked=%0b exp=%0d err=%0d want 1 2 0", locked, expected, err_count); end
    endtask

    task automatic test_single_error();
        do_clear();
        lock_from(8'd16);
        send(8'd99);
        checks++; if (err_pulse !== 1'b1 || err_count !== 4'd1) begin failures++; $display("FAIL single_err got pulse=%0b err=%0d want 1 1", err_pulse, err_count); end
        checks++; if (locked !== 1'b1 || expected !== 8'd21) begin failures++; $display("FAIL single_err_exp got locked=%0b exp=%0d want 1 21", locked, expected); end
        send(8'd21);
        checks++; if (err_pulse !== 1'b0 || expected !== 8'd22) begin failures++; $display("FAIL recover got pulse=%0b exp=%0d want 0 22", err_pulse, expected); end
        send(8'd50);
        send(8'd60);
        checks++; if (locked !== 1'b1 || err_count !== 4'd3 || expected !== 8'd24) begin failures++; $display("FAIL miss_cleared got locked=%0b err=%0d exp=%0d want 1 3 24", locked, err_count, expected); end
    endtask

    task automatic test_loss();
        do_clear();
        lock_from(8'd30);
        send(8'd7);
        checks++; if (state !== 2'd2 || expected !== 8'd35 || err_count !== 4'd1) begin failures++; $display("FAIL loss_1 got state=%0d exp=%0d err=%0d want 2 35 1", state, expected, err_count); end
        send(8'd7);
        send(8'd7);
        checks++; if (state !== 2'd1 || locked !== 1'b0 || expected !== 8'd8) begin failures++; $display("FAIL loss_3 got state=%0d locked=%0b exp=%0d want 1 0 8", state, locked, expected); end
        checks++; if (err_count !== 4'd3 || err_pulse !== 1'b1) begin failures++; $display("FAIL loss_count got err=%0d pulse=%0b want 3 1", err_count, err_pulse); end
        send(8'd50);
        checks++; if (err_pulse !== 1'b0 || err_count !== 4'd3 || expected !== 8'd51 || state !== 2'd1) begin failures++; $display("FAIL search_resync got pulse=%0b err=%0d exp=%0d state=%0d want 0 3 51 1", err_pulse, err_count, expected, state); end
    endtask

    task automatic test_clear();
        send(8'd51);
        send(8'd52);
        send(8'd53);
        checks++; if (locked !== 1'b1 || expected !== 8'd54) begin failures++; $display("FAIL relock got locked=%0b exp=%0d want 1 54", locked, expected); end
        clear = 1'b1;
        send(8'd54);
        clear = 1'b0;
        checks++; if (state !== 2'd0 || locked !== 1'b0 || expected !== 8'd0) begin failures++; $display("FAIL clear_state got state=%0d locked=%0b exp=%0d want 0 0 0", state, locked, expected); end
        checks++; if (err_count !== 4'd0 || sample_count !== 4'd0) begin failures++; $display("FAIL clear_counts got err=%0d smp=%0d want 0 0", err_count, sample_count); end
        send(8'd54);
        checks++; if (state !== 2'd1 || expected !== 8'd55) begin failures++; $display("FAIL after_clear got state=%0d exp=%0d want 1 55", state, expected); end
    endtask

    task automatic test_saturation();
        do_clear();
        for (int r = 1; r <= 6; r++) begin
            lock_from(8'(90 + 10 * r));
            for (int k = 0; k < 3; k++) send(8'd200);
            checks++; if (err_count !== 4'((3 * r > 15) ? 15 : 3 * r)) begin failures++; $display("FAIL err_sat rep=%0d got=%0d want=%0d", r, err_count, (3 * r > 15) ? 15 : 3 * r); end
        end
    endtask

    task automatic test_stats();
        do_clear();
        for (int i = 0; i < 7; i++) begin
            send(8'(i * 3));
            idle_cycle();
        end
`ifdef COUNT_SEQ_CHECKER_STATS_EN
        checks++; if (sample_count !== 4'd7) begin failures++; $display("FAIL stats_count got=%0d want=7", sample_count); end
`else
        checks++; if (sample_count !== 4'd0) begin failures++; $display("FAIL stats_count got=%0d want=0", sample_count); end
`endif
    endtask

    task automatic test_reset_mid_lock();
        do_clear();
        lock_from(8'd0);
        checks++; if (locked !== 1'b1) begin failures++; $display("FAIL pre_reset_lock got=%0b want=1", locked); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (state !== 2'd0 || locked !== 1'b0 || expected !== 8'd0 || err_count !== 4'd0) begin failures++; $display("FAIL async_reset got state=%0d locked=%0b exp=%0d err=%0d want 0 0 0 0", state, locked, expected, err_count); end
        #2;
        reset = 1'b0;
        send(8'd77);
        checks++; if (state !== 2'd1 || expected !== 8'd78) begin failures++; $display("FAIL post_reset got state=%0d exp=%0d want 1 78", state, expected); end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_wrap();
        test_single_error();
        test_loss();
        test_clear();
        test_saturation();
        test_stats();
        test_reset_mid_lock();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
